// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 datapath.
package xs3_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [3:0] xs3_t;

    localparam xs3_t XS3_OFFSET = 4'd3;
    localparam bcd_t BCD_MAX    = 4'd9;

    // True when the 4-bit code is a legal decimal digit.
    function automatic logic is_bcd(input bcd_t code);
        return (code <= BCD_MAX);
    endfunction

endpackage

// File: rtl/xs3_enc.sv
// Purely combinational BCD digit to Excess-3 encoder with a non-BCD flag.
// Codes above 9 still produce the 4-bit wrapped sum; err qualifies them.
module xs3_enc
    import xs3_pkg::*;
(
    input  bcd_t code,
    output xs3_t y,
    output logic err
);

    // Add the Excess-3 bias (mod 16) and flag codes outside 0..9.
    always_comb begin
        y   = code + XS3_OFFSET;
        err = !is_bcd(code);
    end

endmodule

// File: rtl/bcd_to_xs3.sv
// Registered BCD to Excess-3 converter with a saturating count of
// accepted non-BCD codes. One cycle of latency, one digit per cycle.
module bcd_to_xs3
    import xs3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [3:0]       y,
    output logic             out_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bcd_t code;
    xs3_t enc_y;
    logic enc_err;

    assign code = {a, b, c, d};

    xs3_enc u_enc (
        .code (code),
        .y    (enc_y),
        .err  (enc_err)
    );

    // Output register: y only loads on an accepted digit so it holds across
    // idle cycles, and err is forced low when no digit was taken, so unknown
    // inputs during idle cycles never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= 4'b0000;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y   <= enc_y;
                err <= enc_err;
            end else begin
                err <= 1'b0;
            end
        end
    end

    // Invalid-code counter: clear wins over a same-cycle increment, and the
    // count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (in_valid && enc_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_bcd_to_xs3.sv
// Self-checking bench for bcd_to_xs3: directed scenarios followed by a
// random phase, compared against an arithmetic reference model. A second
// instance with a 2-bit counter exercises saturation.
module tb_bcd_to_xs3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d;
    logic       in_valid;
    logic       cnt_clr;

    logic [3:0] y, y_s;
    logic       out_valid, out_valid_s;
    logic       err, err_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    int tests    = 0;
    int failures = 0;

    int exp_y, exp_valid, exp_err, exp_cnt8, exp_cnt2;

    always #5 clk = ~clk;

    bcd_to_xs3 #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y), .out_valid(out_valid), .err(err), .err_cnt(err_cnt)
    );

    bcd_to_xs3 #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y_s), .out_valid(out_valid_s), .err(err_s), .err_cnt(err_cnt_s)
    );

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs (code < 0 means drive X on a..d), let one
    // rising edge pass, update the reference model, then settle to the
    // falling edge where outputs are compared.
    task automatic applyStimulus(input logic rst, input logic iv, input logic clr, input int code);
        rst_n    = rst;
        in_valid = iv;
        cnt_clr  = clr;
        if (code < 0) {a, b, c, d} = 4'bxxxx;
        else          {a, b, c, d} = code[3:0];
        @(posedge clk);
        if (!rst) begin
            exp_y = 0; exp_valid = 0; exp_err = 0; exp_cnt8 = 0; exp_cnt2 = 0;
        end else begin
            exp_valid = iv;
            if (iv) begin
                exp_y   = (code + 3) % 16;
                exp_err = (code > 9);
            end else begin
                exp_err = 0;
            end
            if (clr) begin
                exp_cnt8 = 0;
                exp_cnt2 = 0;
            end else if (iv && code > 9) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3)   exp_cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".y"},        32'(y),           32'(exp_y));
        checkOne({tag, ".valid"},    32'(out_valid),   32'(exp_valid));
        checkOne({tag, ".err"},      32'(err),         32'(exp_err));
        checkOne({tag, ".cnt"},      32'(err_cnt),     32'(exp_cnt8));
        checkOne({tag, ".y_sat"},    32'(y_s),         32'(exp_y));
        checkOne({tag, ".cnt_sat"},  32'(err_cnt_s),   32'(exp_cnt2));
    endtask

    initial begin
        exp_y = 0; exp_valid = 0; exp_err = 0; exp_cnt8 = 0; exp_cnt2 = 0;
        rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; {a, b, c, d} = 4'b0000;
        @(negedge clk);

        // Reset held for two cycles with a digit presented.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 9);
            checkOutput("reset");
        end
        checkOne("reset.y_const", 32'(y), 32'd0);

        // Full back-to-back sweep of all sixteen codes.
        for (int code = 0; code < 16; code++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, code);
            checkOutput($sformatf("sweep%0d", code));
        end
        checkOne("sweep.cnt_end", 32'(err_cnt), 32'd6);

        // Digit followed by two idle cycles with an invalid code on the pins.
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        checkOutput("gap0");
        checkOne("gap0.y_const", 32'(y), 32'h8);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 15);
            checkOutput($sformatf("gap%0d", i + 1));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, -1);
        checkOutput("gapX");

        // Clear colliding with an invalid-code increment.
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 11);
        checkOne("clr.pre_cnt", 32'(err_cnt), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 12);
        checkOutput("clr_collide");
        checkOne("clr.cnt_const", 32'(err_cnt), 32'd0);

        // Saturation of the 2-bit counter instance.
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 14);
            checkOutput($sformatf("sat%0d", i));
            checkOne($sformatf("sat%0d.const", i), 32'(err_cnt_s), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Reset pulse in the middle of a sweep, landing on code 7.
        for (int code = 0; code < 16; code++) begin
            applyStimulus((code == 7) ? 1'b0 : 1'b1, 1'b1, 1'b0, code);
            checkOutput($sformatf("midrst%0d", code));
        end

        // Random traffic, including X on idle inputs and occasional clear/reset.
        for (int i = 0; i < 300; i++) begin
            logic r_rst, r_iv, r_clr;
            int   r_code;
            r_rst  = ($urandom_range(0, 39) != 0);
            r_iv   = ($urandom_range(0, 3) != 0);
            r_clr  = ($urandom_range(0, 29) == 0);
            r_code = $urandom_range(0, 15);
            if (!r_iv && $urandom_range(0, 1) == 1) r_code = -1;
            applyStimulus(r_rst, r_iv, r_clr, r_code);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_xs3.md
Name: bcd_to_xs3

Overview:
- Registered BCD-to-Excess-3 code converter. Accepts one 4-bit BCD digit as four scalar bits (a = MSB, d = LSB) and produces the 4-bit Excess-3 code one clock later.
- Flags non-BCD input codes (10..15) and keeps a saturating count of them.
- Sits in the digit-encoding datapath, ahead of XS3 arithmetic/self-complementing logic.

Parameters:
- CNT_W, 8, width of the invalid-code counter err_cnt (minimum 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  1  BCD bit 3 (MSB, weight 8)
- b  input  1  BCD bit 2 (weight 4)
- c  input  1  BCD bit 1 (weight 2)
- d  input  1  BCD bit 0 (LSB, weight 1)
- in_valid  input  1  a/b/c/d carry a digit this cycle
- cnt_clr  input  1  synchronous clear of err_cnt
- y  output  4  Excess-3 code, y[3] = MSB
- out_valid  output  1  y/err valid this cycle
- err  output  1  captured code was not BCD (> 9)
- err_cnt  output  CNT_W  saturating count of accepted invalid codes

Behaviour:
- One clock; all state updates on rising clk edge. No combinational input-to-output path.
- Reset: when rst_n = 0 at a clock edge, y = 4'b0000, out_valid = 0, err = 0, err_cnt = 0. Reset overrides all other inputs, including in_valid and cnt_clr.
- Let code = {a,b,c,d}.
- Accepted digit (rst_n = 1, in_valid = 1):
  - y <= (code + 3) mod 16, 4-bit wrap.
  - out_valid <= 1.
  - err <= (code > 9).
- Latency: exactly 1 cycle. Back-to-back in_valid gives one result per cycle with no bubbles.
- Idle cycle (in_valid = 0): out_valid <= 0, err <= 0, y holds its last value.
- Mapping, required for all 16 codes:
  - 0→3, 1→4, 2→5, 3→6, 4→7, 5→8, 6→9, 7→10, 8→11, 9→12
  - 10→13, 11→14, 12→15, 13→0, 14→1, 15→2 (each of 10..15 with err = 1)
- Invalid codes still produce the wrapped sum on y; downstream logic qualifies y with err.
- err_cnt:
  - Increments by 1 on each accepted digit with code > 9.
  - Saturates at 2^CNT_W − 1 and does not wrap.
  - cnt_clr = 1 forces err_cnt <= 0 on that edge. Clear has priority over a simultaneous increment, so the result is 0.
- Inputs a..d are ignored when in_valid = 0; X on them must not propagate when in_valid = 0.
- Reset asserted mid-stream: the next cycle shows out_valid = 0 and y = 0. The in-flight digit is dropped and not counted.

Decomposition:
- Shared package xs3_pkg:
  - XS3_OFFSET = 4'd3
  - BCD_MAX = 4'd9
  - typedef bcd_t / xs3_t as 4-bit logic
- Optional sub-module xs3_enc: purely combinational code→{y, err}. Top level holds the registers and the counter.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with in_valid = 1, code = 1001 -> y = 0000, out_valid = 0, err = 0, err_cnt = 0.
- Full sweep: code 0000..1111 back-to-back with in_valid = 1 -> one cycle later each: y = 0011, 0100, …, 1100 for 0..9 with err = 0; then 1101, 1110, 1111, 0000, 0001, 0010 for 10..15 with err = 1; out_valid = 1 throughout; err_cnt = 6 at end.
- Gaps: code 0101 with in_valid = 1, then 2 cycles in_valid = 0 with code = 1111 -> y = 1000 held, out_valid 1→0→0, err = 0, err_cnt unchanged.
- Clear/increment collision: err_cnt = 3, apply code 1100 with cnt_clr = 1 -> err_cnt = 0, y = 1111, err = 1.
- Saturation with CNT_W = 2: 5 consecutive code 1110 digits -> err_cnt goes 1, 2, 3, 3, 3.
- Mid-stream reset: during the sweep, assert rst_n = 0 for one cycle at code 0111 -> next cycle out_valid = 0, y = 0000; the stream resumes correctly afterward.
